ldpc_iter_ctrl: RTL and testbench
=================================

LDPC_ITER_CTRL -- requirements
Module: ldpc_iter_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge), rst_n.
REQ-002 Parameters SHALL be: N, default 576, codeword length in bits; data_w, default 8, LLR width; iter_w, default 8, iteration counter width.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  input frame valid
- in_ready  out  1  input frame accepted when high with in_valid
- in_llr  in  N*data_w  channel LLRs
- max_iter  in  iter_w  iteration limit, sampled with the frame
- llr  out  N*data_w  LLRs driven to the VNU array
- dp_rst  out  1  clears CNU state
- dp_en  out  1  runs one datapath iteration
- dec  in  N  hard decisions from the VNU array
- chk_ok  in  1  syndrome zero for dec
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_bits  out  N  decoded word
- out_iter  out  iter_w  iterations used
- out_status  out  2  {limit_hit, not_converged}

Function
REQ-004 The FSM SHALL have the states IDLE, LOAD, ITER and DONE.
REQ-005 IDLE: in_ready=1; on in_valid&&in_ready, capture in_llr into llr and max_iter into lim_reg (0 stored as 1), then go to LOAD.
REQ-006 LOAD: exactly one cycle; dp_rst=1 and iter_cnt cleared to 0; go to ITER.
REQ-007 ITER cycle with iter_cnt=k: chk_ok reflects decisions after k iterations.
REQ-008 If chk_ok=1 in ITER: go to DONE; latch out_bits=dec, out_iter=k, out_status=2'b00; dp_en=0 that cycle.
REQ-009 Else, if k==lim_reg: go to DONE; latch out_bits=dec, out_iter=k, out_status=2'b11; dp_en=0.
REQ-010 Otherwise: dp_en=1 (combinational) and iter_cnt increments by 1; stay in ITER.
REQ-011 The convergence check SHALL take priority over the limit when both conditions hold (status 2'b00).
REQ-012 iter_cnt SHALL never wrap; lim_reg is at most 2^iter_w-1, so k reaches the limit first.
REQ-013 DONE: out_valid=1; out_bits, out_iter and out_status SHALL hold stable until out_valid&&out_ready.
REQ-014 On the DONE handshake, the next state SHALL be LOAD when a frame is pending (REQ-018), otherwise IDLE; out_valid deasserts in the next cycle.
REQ-015 dp_en and dp_rst SHALL be 0 in IDLE and DONE; dp_en SHALL be 0 in LOAD.
REQ-016 Decode latency SHALL be: accept-to-out_valid = k+2 cycles, where k is out_iter.

Reset
REQ-017 While rst_n=0:
- state=IDLE; llr, lim_reg, iter_cnt, out_bits, out_iter, out_status and the prefetch buffer all 0; pf_vld=0.
- out_valid=0, in_ready=0, dp_en=0, dp_rst=1 (combinational from rst_n).
- Reset mid-ITER or mid-DONE SHALL drop the frame silently; the first cycle after release is IDLE with in_ready=1.

Configuration
REQ-018 With macro LDPC_CTRL_PREFETCH_EN defined:
- A one-frame buffer (pf_llr, pf_lim, pf_vld) SHALL be added.
- In LOAD, ITER and DONE: in_ready=!pf_vld; an accepted frame is stored there and pf_vld is set.
- On the DONE handshake with pf_vld=1: the buffer moves into llr/lim_reg, pf_vld is cleared, and the FSM goes to LOAD.
- On the DONE handshake with pf_vld=0 and in_valid in the same cycle: the frame is accepted directly into llr/lim_reg, and the FSM goes to LOAD.
REQ-019 Without the macro: in_ready=1 only in IDLE; the FSM always returns to IDLE after DONE; no buffer logic is synthesised.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Frame with max_iter=10, chk_ok high at k=3 -> dp_en pulses 3 times; out_iter=3, out_status=00; out_valid 5 cycles after accept.
- max_iter=4, chk_ok never high -> 4 dp_en pulses; out_iter=4, out_status=11, out_bits=dec at k=4.
- max_iter=0, chk_ok low -> one dp_en; out_iter=1, out_status=11.
- chk_ok high at k=0 -> zero dp_en; out_iter=0, status=00; hold out_ready=0 for 5 cycles -> outputs stable; out_valid drops the cycle after handshake.
- PREFETCH_EN: second frame offered during ITER -> accepted, in_ready low until DONE handshake, then LOAD next cycle with the second LLRs; without macro, in_ready stays 0 until IDLE.
- rst_n pulsed low at ITER k=2 -> out_valid never asserts; dp_rst=1 during reset; in_ready=1 one cycle after release.

Source files
------------

// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: iteration controller for a flooding LDPC decoder.
// Loads a frame of channel LLRs, runs datapath iterations until the syndrome
// check passes or the per-frame iteration limit is reached, then presents the
// decoded word with the iteration count and a status code.
// Optional feature: define LDPC_CTRL_PREFETCH_EN to add a one-frame input
// buffer so the next frame can be accepted while the current one decodes.
module ldpc_iter_ctrl #(
    parameter int N      = 576,
    parameter int data_w = 8,
    parameter int iter_w = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*data_w-1:0]   in_llr,
    input  logic [iter_w-1:0]     max_iter,
    output logic [N*data_w-1:0]   llr,
    output logic                  dp_rst,
    output logic                  dp_en,
    input  logic [N-1:0]          dec,
    input  logic                  chk_ok,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_bits,
    output logic [iter_w-1:0]     out_iter,
    output logic [1:0]            out_status
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N*data_w-1:0]   r_llr;
    logic [iter_w-1:0]     r_lim;
    logic [iter_w-1:0]     r_iter_cnt;
    logic [N-1:0]          r_out_bits;
    logic [iter_w-1:0]     r_out_iter;
    logic [1:0]            r_out_status;
    logic [iter_w-1:0]     w_lim_in;
    logic                  w_load_new;
    logic                  w_iter_end;
`ifdef LDPC_CTRL_PREFETCH_EN
    logic [N*data_w-1:0]   r_pf_llr;
    logic [iter_w-1:0]     r_pf_lim;
    logic                  r_pf_vld;
    logic                  w_load_pf;
    logic                  w_pf_store;
`endif

    // A limit of zero would never run an iteration, so it is promoted to one.
    assign w_lim_in   = (max_iter == '0) ? iter_w'(1) : max_iter;
    // Convergence is tested before the limit, so a word that converges on the
    // last allowed iteration still reports success.
    assign w_iter_end = (r_state == S_ITER) && (chk_ok || (r_iter_cnt == r_lim));

    assign llr        = r_llr;
    assign out_bits   = r_out_bits;
    assign out_iter   = r_out_iter;
    assign out_status = r_out_status;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic and handshake/datapath control outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        dp_rst      = !rst_n;
        dp_en       = 1'b0;
        out_valid   = 1'b0;
        w_load_new  = 1'b0;
`ifdef LDPC_CTRL_PREFETCH_EN
        w_load_pf   = 1'b0;
        w_pf_store  = 1'b0;
        if (r_state != S_IDLE) begin
            in_ready   = !r_pf_vld;
            // A frame arriving on the DONE handshake goes straight to the datapath.
            w_pf_store = in_valid && !r_pf_vld && !((r_state == S_DONE) && out_ready);
        end
`endif
        case (r_state)
            S_IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    w_load_new  = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                dp_rst      = 1'b1;
                w_state_nxt = S_ITER;
            end
            S_ITER: begin
                if (w_iter_end) w_state_nxt = S_DONE;
                else            dp_en       = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
`ifdef LDPC_CTRL_PREFETCH_EN
                    if (r_pf_vld) begin
                        w_load_pf   = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else if (in_valid) begin
                        w_load_new  = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Working frame: LLRs driven to the VNU array and the iteration limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_llr <= '0;
            r_lim <= '0;
        end else if (w_load_new) begin
            r_llr <= in_llr;
            r_lim <= w_lim_in;
`ifdef LDPC_CTRL_PREFETCH_EN
        end else if (w_load_pf) begin
            r_llr <= r_pf_llr;
            r_lim <= r_pf_lim;
`endif
        end
    end

    // Iteration counter: cleared in LOAD, advanced once per datapath iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_iter_cnt <= '0;
        else if (r_state == S_LOAD)  r_iter_cnt <= '0;
        else if (dp_en)              r_iter_cnt <= r_iter_cnt + 1'b1;
    end

    // Result registers, captured on the last ITER cycle and held through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_bits   <= '0;
            r_out_iter   <= '0;
            r_out_status <= 2'b00;
        end else if (w_iter_end) begin
            r_out_bits   <= dec;
            r_out_iter   <= r_iter_cnt;
            r_out_status <= chk_ok ? 2'b00 : 2'b11;
        end
    end

`ifdef LDPC_CTRL_PREFETCH_EN
    // Prefetch buffer: holds one waiting frame until the current result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pf_llr <= '0;
            r_pf_lim <= '0;
            r_pf_vld <= 1'b0;
        end else if (w_pf_store) begin
            r_pf_llr <= in_llr;
            r_pf_lim <= w_lim_in;
            r_pf_vld <= 1'b1;
        end else if (w_load_pf) begin
            r_pf_vld <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// tb_ldpc_iter_ctrl: scoreboard bench for ldpc_iter_ctrl with a small
// behavioural model of the VNU/CNU array. Works with or without
// LDPC_CTRL_PREFETCH_EN defined.
module tb_ldpc_iter_ctrl;

    localparam int N  = 16;
    localparam int DW = 8;
    localparam int IW = 4;
    localparam int NEVER = 255;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_llr;
    logic [IW-1:0]     max_iter;
    logic [N*DW-1:0]   llr;
    logic              dp_rst;
    logic              dp_en;
    logic [N-1:0]      dec;
    logic              chk_ok;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_bits;
    logic [IW-1:0]     out_iter;
    logic [1:0]        out_status;

    ldpc_iter_ctrl #(.N(N), .data_w(DW), .iter_w(IW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_llr(in_llr), .max_iter(max_iter), .llr(llr), .dp_rst(dp_rst),
        .dp_en(dp_en), .dec(dec), .chk_ok(chk_ok), .out_valid(out_valid),
        .out_ready(out_ready), .out_bits(out_bits), .out_iter(out_iter),
        .out_status(out_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N*DW-1:0] llr;
        logic [N-1:0]    bits;
        int              iter;
        logic [1:0]      st;
        int              hold;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   env_cnt = 0;

    // Datapath model: after c iterations the hard decision for bit i is bit
    // (c mod DW) of LLR i; the word is valid when c equals LLR lane 0.
    function automatic logic [N-1:0] dec_of(input logic [N*DW-1:0] l, input int c);
        logic [N-1:0] d;
        for (int i = 0; i < N; i++) d[i] = l[i*DW + (c % DW)];
        return d;
    endfunction

    assign dec    = dec_of(llr, env_cnt);
    assign chk_ok = (env_cnt == int'(llr[DW-1:0]));

    always @(posedge clk) cyc <= cyc + 1;

    // Iteration counter of the datapath model, driven by dp_rst/dp_en.
    initial begin
        logic sr, se;
        forever begin
            @(negedge clk);
            sr = dp_rst;
            se = dp_en;
            @(posedge clk);
            #1;
            if (sr)      env_cnt = 0;
            else if (se) env_cnt = env_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Issue one frame; the expected result is derived from the frame rules.
    task automatic send_frame(input int conv, input int mi, input int hold);
        logic [N*DW-1:0] l;
        exp_t e;
        int lim, w;
        for (int i = 0; i < N; i++) l[i*DW +: DW] = DW'($urandom);
        l[DW-1:0] = DW'(conv);
        lim = (mi == 0) ? 1 : mi;
        if (conv <= lim) begin
            e.iter = conv;
            e.st   = 2'b00;
        end else begin
            e.iter = lim;
            e.st   = 2'b11;
        end
        e.bits = dec_of(l, e.iter);
        e.llr  = l;
        e.hold = hold;
        in_llr   = l;
        max_iter = IW'(mi);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
        end else begin
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(posedge clk);
            #1;
            w++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
        end
    endtask

    // Result consumer: each result is held off for its requested number of cycles.
    initial begin
        int h;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                h = (exp_q.size() != 0) ? exp_q[0].hold : 0;
                repeat (h) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard and protocol rules.
    initial begin
        int   inflight, pulses, load_cyc;
        logic prev_valid, prev_fire, exp_rdy;
        logic [N-1:0]  p_bits;
        logic [IW-1:0] p_iter;
        logic [1:0]    p_st;
        exp_t e;
        inflight = 0; pulses = 0; load_cyc = 0;
        prev_valid = 1'b0; prev_fire = 1'b0;
        p_bits = '0; p_iter = '0; p_st = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_ctrl", {252'd0, out_valid, in_ready, dp_en, dp_rst}, 256'b0001);
                check("reset_llr", 256'(llr), 256'd0);
                check("reset_result", 256'({out_bits, out_iter, out_status}), 256'd0);
                inflight = 0; pulses = 0;
                prev_valid = 1'b0; prev_fire = 1'b0;
            end else begin
`ifdef LDPC_CTRL_PREFETCH_EN
                exp_rdy = (inflight < 2);
`else
                exp_rdy = (inflight == 0);
`endif
                check("in_ready", 256'(in_ready), 256'(exp_rdy));
                if (dp_rst) begin
                    load_cyc = cyc;
                    pulses   = 0;
                    if (exp_q.size() == 0) check("load_unexpected", 256'(1), 256'(0));
                    else                   check("load_llr", 256'(llr), 256'(exp_q[0].llr));
                end
                if (dp_en) pulses++;
                if (prev_fire) check("valid_drop", 256'(out_valid), 256'(0));
                if (out_valid) begin
                    check("done_dp_ctrl", 256'({dp_en, dp_rst}), 256'(0));
                    if (exp_q.size() == 0) begin
                        check("out_unexpected", 256'(out_valid), 256'(0));
                    end else begin
                        e = exp_q[0];
                        if (!prev_valid) begin
                            check("latency", 256'(cyc - load_cyc), 256'(e.iter + 2));
                            check("dp_en_pulses", 256'(pulses), 256'(e.iter));
                            check("out_bits", 256'(out_bits), 256'(e.bits));
                            check("out_iter", 256'(out_iter), 256'(e.iter));
                            check("out_status", 256'(out_status), 256'(e.st));
                        end else begin
                            check("hold_stable", 256'({out_bits, out_iter, out_status}),
                                  256'({p_bits, p_iter, p_st}));
                        end
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                if (in_valid && in_ready)   inflight++;
                if (out_valid && out_ready) inflight--;
                prev_fire  = out_valid && out_ready;
                prev_valid = out_valid && !out_ready;
                p_bits = out_bits; p_iter = out_iter; p_st = out_status;
            end
        end
    end

    // Stimulus: directed scenarios, a reset mid-decode, then random traffic.
    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; in_llr = '0; max_iter = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        send_frame(3, 10, 0);        wait_drain();   // converge at k=3
        send_frame(NEVER, 4, 0);     wait_drain();   // limit of 4
        send_frame(NEVER, 0, 0);     wait_drain();   // limit 0 runs once
        send_frame(0, 5, 5);         wait_drain();   // immediate convergence, held result
        send_frame(15, 15, 1);       wait_drain();   // converge exactly at max limit
        send_frame(NEVER, 15, 0);    wait_drain();   // counter reaches its maximum
        send_frame(NEVER, 8, 2);                     // second frame offered mid-ITER
        send_frame(2, 6, 0);
        send_frame(1, 3, 0);
        wait_drain();

        // Reset while iterating at k=2: the frame is dropped.
        send_frame(NEVER, 10, 0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(env_cnt == 2 && dp_en) && w < 100);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);

        for (int f = 0; f < 40; f++) begin
            int conv, gap;
            conv = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 15));
            send_frame(conv, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
            gap = int'($urandom_range(0, 3));
            if (gap != 0) idle(gap);
        end
        wait_drain();
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
